tamagotchi_input_conditioner: RTL and testbench
===============================================

# tamagotchi_input_conditioner

Front-end conditioning stage placed directly upstream of the central control FSM in the Tamagotchi top level. Synchronizes, debounces and edge-detects the raw board buttons and tilt sensor. Provides single-cycle press pulses to the FSM. Detects the test-button long press that toggles test mode, and counts short test presses into the 4-bit `pulse_test` value the FSM uses to accelerate state changes.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive identical synchronized samples needed to accept a new level (20 ms at 50 MHz).
- `LONGPRESS_CYCLES`, 250_000_000: debounced test-button hold length that counts as a long press (5 s at 50 MHz).
- `BTN_ACTIVE_LOW`, 1: raw button/tilt polarity; 1 means pin low = pressed/tilted.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `btn_raw`  in  5  raw buttons, index {4:test, 3:play, 2:feed, 1:awake, 0:sleep}; asynchronous to `clk`.
- `giro_raw`  in  1  raw tilt sensor; asynchronous.
- `btn_level`  out  5  debounced pressed level, active-high.
- `btn_press`  out  5  one-cycle pulse on each debounced press.
- `giro_level`  out  1  debounced tilt level, active-high.
- `giro_edge`  out  1  one-cycle pulse on any debounced tilt change.
- `test_long`  out  1  one-cycle pulse when the test button has been held `LONGPRESS_CYCLES`.
- `test_short`  out  1  one-cycle pulse on test release before long-press threshold.
- `test_mode`  out  1  test-mode flag, toggled by `test_long`.
- `pulse_test`  out  4  short-press counter, valid in test mode.

## Operation
- Each of the 6 channels:
  - Polarity-normalizes the input (XOR with `BTN_ACTIVE_LOW`).
  - Passes it through a 2-flop synchronizer.
  - Compares the synchronized sample with the stable level.
- Debounce counter:
  - Clears whenever the sample equals the stable level.
  - Otherwise increments.
  - On reaching `DEBOUNCE_CYCLES-1`, the stable level flips and the counter clears.
- Press pulse: `btn_press[i]` is asserted on the same edge that `btn_level[i]` goes 0→1. Releases produce no press pulse.
- `giro_edge` is asserted on the same edge as either `giro_level` transition.
- Hold counter on debounced test level:
  - Counts while `btn_level[4]`=1 and saturates at `LONGPRESS_CYCLES`.
  - On reaching `LONGPRESS_CYCLES`, `test_long` pulses once per hold.
  - On 1→0 of `btn_level[4]` with the count below threshold, `test_short` pulses.
  - Release after a long press emits nothing.
  - The counter clears on release.
- Test mode:
  - `test_long` toggles `test_mode`.
  - With `test_mode`=1, each `test_short` increments `pulse_test`, wrapping 15→0.
  - Leaving test mode (1→0) clears `pulse_test` to 0 in the same cycle.
  - `test_short` with `test_mode`=0 leaves `pulse_test` at 0.
- `btn_press[4]` still pulses on every test press.
- Simultaneous events:
  - Any combination of channels may pulse in the same cycle; no priority here, arbitration belongs to the FSM.
  - `test_long` and `test_short` are mutually exclusive by construction.
- Channel state: stable-level register, debounce counter (`$clog2(DEBOUNCE_CYCLES)` bits) and hold counter (`$clog2(LONGPRESS_CYCLES+1)` bits). All are unsigned.

## Timing
- Reset (`rst`=0 at a rising edge) clears everything:
  - Synchronizers, counters and stable levels go to released (0).
  - All outputs go to 0, including `test_mode` and `pulse_test`.
- A button held through reset deassertion is treated as a fresh press: `btn_press` pulses after the debounce latency.
- Reset mid-hold discards a pending long press.
- Latency:
  - The raw input is sampled at edge 0.
  - It appears at the synchronizer output at edge 2.
  - `btn_level`/`btn_press` update at edge 2+`DEBOUNCE_CYCLES`-1, if the input stays stable.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- `test_long` fires `LONGPRESS_CYCLES` cycles after `btn_level[4]` rises. `test_mode` updates on the following edge.
- `test_short` fires on the edge `btn_level[4]` falls. `pulse_test` updates on the following edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `tamagotchi_pkg` holds:
  - Button index constants (`BTN_SLEEP`=0 … `BTN_TEST`=4).
  - Default `DEBOUNCE_CYCLES`/`LONGPRESS_CYCLES`.
  - `PULSE_TEST_W`=4.
  The FSM imports the same constants.
- Sub-module `btn_debounce` handles one channel (sync + debounce + rise/fall pulses), parameterized by `DEBOUNCE_CYCLES`. It is instantiated 6 times in a generate loop.
- Long-press, test-mode and `pulse_test` logic stays in the top module.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONGPRESS_CYCLES`=20, `BTN_ACTIVE_LOW`=1.
1. Feed press:
   - Stimulus: drive `btn_raw[2]` low at edge 10, hold 30 cycles.
   - Required: `btn_level[2]` rises and `btn_press[2]` pulses exactly once at edge 15; no pulse on release; level falls 5 edges after release.
2. Bounce rejection:
   - Stimulus: toggle `btn_raw[3]` every 2 cycles for 20 cycles, then release.
   - Required: `btn_level[3]` and `btn_press[3]` stay 0 throughout.
3. Long press and short presses in test mode:
   - Stimulus: hold test 30 cycles.
   - Required: `test_long` pulses once, `test_mode`=1, no `test_short` on release.
   - Then: 3 short test presses of 8 cycles each.
   - Required: 3 `test_short` pulses, `pulse_test`=3.
   - Then: a second long press.
   - Required: `test_mode`=0 and `pulse_test`=0.
4. Wrap and idle behaviour:
   - In test mode, 17 short presses → `pulse_test`=1.
   - In normal mode, a short press → `test_short` pulses and `pulse_test` stays 0.
5. Simultaneous events and tilt:
   - Stimulus: press sleep and play on the same cycle while toggling `giro_raw`.
   - Required: `btn_press[0]` and `btn_press[3]` pulse on the same cycle; `giro_edge` pulses on each debounced tilt change.
6. Reset mid-operation:
   - Stimulus: assert `rst`=0 for 1 cycle during a 15-cycle test hold with `test_mode`=1.
   - Required:
     - All outputs are 0 at the next edge.
     - With the button still held, `btn_press[4]` pulses 5 edges after reset release.
     - `test_long` fires 20 cycles after that pulse.
     - `test_mode` ends at 1.

Source files
------------

// File: rtl/tamagotchi_pkg.sv
// Constants shared by the Tamagotchi input conditioner and the central control FSM.
// Button indices, default timing constants and the pulse_test width live here.
package tamagotchi_pkg;

   localparam int BTN_SLEEP = 0;
   localparam int BTN_AWAKE = 1;
   localparam int BTN_FEED  = 2;
   localparam int BTN_PLAY  = 3;
   localparam int BTN_TEST  = 4;
   localparam int NUM_BTN   = 5;

   localparam int DEF_DEBOUNCE_CYCLES  = 1_000_000;
   localparam int DEF_LONGPRESS_CYCLES = 250_000_000;

   localparam int PULSE_TEST_W = 4;

   typedef logic [NUM_BTN-1:0]      btn_vec_t;
   typedef logic [PULSE_TEST_W-1:0] pulse_test_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tamagotchi_input_conditioner_if.sv
// Signal bundle between the raw board inputs, the conditioner and the control FSM.
// slave = the conditioner itself, master = the board/FSM side.
interface tamagotchi_input_conditioner_if;
   import tamagotchi_pkg::*;

   btn_vec_t    btn_raw;
   logic        giro_raw;
   btn_vec_t    btn_level;
   btn_vec_t    btn_press;
   logic        giro_level;
   logic        giro_edge;
   logic        test_long;
   logic        test_short;
   logic        test_mode;
   pulse_test_t pulse_test;

   modport master (
      output btn_raw, giro_raw,
      input  btn_level, btn_press, giro_level, giro_edge,
      input  test_long, test_short, test_mode, pulse_test
   );

   modport slave (
      input  btn_raw, giro_raw,
      output btn_level, btn_press, giro_level, giro_edge,
      output test_long, test_short, test_mode, pulse_test
   );

endinterface

// File: rtl/btn_debounce.sv
// One input channel: 2-flop synchronizer, saturating debounce counter, stable level
// and one-cycle rise/fall pulses coinciding with the level change.
module btn_debounce
   import tamagotchi_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic fall_next
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          flip;

   // The level flips on the edge that sees the last of the required differing samples.
   assign flip      = (sync2 != level) && (cnt == CNT_LAST);
   assign fall_next = flip && level;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= flip && !level;
         fall <= flip && level;
         if ((sync2 == level) || flip) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (flip) begin
            level <= ~level;
         end
      end
   end

endmodule

// File: rtl/tamagotchi_input_conditioner.sv
// Conditions the five buttons and the tilt sensor for the control FSM, and derives
// long/short test-button events, the test-mode flag and the short-press counter.
module tamagotchi_input_conditioner
   import tamagotchi_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
   parameter int LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES,
   parameter bit BTN_ACTIVE_LOW   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   tamagotchi_input_conditioner_if.slave cond
);

   localparam int NUM_CH = NUM_BTN + 1;
   localparam int GIRO   = NUM_BTN;

   localparam int             HW        = cnt_width(LONGPRESS_CYCLES + 1);
   localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONGPRESS_CYCLES);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(LONGPRESS_CYCLES - 1);

   logic [NUM_CH-1:0] ch_raw;
   logic [NUM_CH-1:0] ch_level;
   logic [NUM_CH-1:0] ch_rise;
   logic [NUM_CH-1:0] ch_fall;
   logic [NUM_CH-1:0] ch_fall_next;

   logic [HW-1:0] hold;
   logic          test_long_q;
   logic          test_short_q;
   logic          test_mode_q;
   pulse_test_t   pulse_test_q;
   logic          test_level;
   logic          unused_ch;

   assign ch_raw = {cond.giro_raw, cond.btn_raw} ^ {NUM_CH{BTN_ACTIVE_LOW}};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk       (clk),
         .rst       (rst),
         .raw       (ch_raw[i]),
         .level     (ch_level[i]),
         .rise      (ch_rise[i]),
         .fall      (ch_fall[i]),
         .fall_next (ch_fall_next[i])
      );
   end

   assign test_level = ch_level[BTN_TEST];

   // Button falls and most next-fall flags have no consumer; only the test button's matters.
   assign unused_ch = ^{ch_fall[NUM_BTN-1:0], ch_fall_next[GIRO], ch_fall_next[BTN_TEST-1:0]};

   // A release whose hold never reached the threshold is a short press; the edge that
   // completes the hold fires the long press, so the two cannot coincide.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold         <= '0;
         test_long_q  <= 1'b0;
         test_short_q <= 1'b0;
      end else begin
         test_long_q  <= test_level && (hold == HOLD_LAST);
         test_short_q <= ch_fall_next[BTN_TEST] && (hold < HOLD_LAST);
         if (!test_level) begin
            hold <= '0;
         end else if (hold != HOLD_MAX) begin
            hold <= hold + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         test_mode_q  <= 1'b0;
         pulse_test_q <= '0;
      end else begin
         test_mode_q <= test_mode_q ^ test_long_q;
         if (test_mode_q && test_long_q) begin
            pulse_test_q <= '0;
         end else if (test_mode_q && test_short_q) begin
            pulse_test_q <= pulse_test_q + 1'b1;
         end
      end
   end

   assign cond.btn_level  = ch_level[NUM_BTN-1:0];
   assign cond.btn_press  = ch_rise[NUM_BTN-1:0];
   assign cond.giro_level = ch_level[GIRO];
   assign cond.giro_edge  = ch_rise[GIRO] | ch_fall[GIRO];
   assign cond.test_long  = test_long_q;
   assign cond.test_short = test_short_q;
   assign cond.test_mode  = test_mode_q;
   assign cond.pulse_test = pulse_test_q;

endmodule

// File: tb/tb_tamagotchi_input_conditioner.sv
// Directed bench for the input conditioner with short debounce/long-press settings.
// Inputs change and outputs are checked on the falling clock edge.
module tb_tamagotchi_input_conditioner;
   import tamagotchi_pkg::*;

   localparam int DB = 4;
   localparam int LP = 20;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   int   n_short = 0;
   int   n_long = 0;
   int   n_press4 = 0;

   always #5 clk = ~clk;

   tamagotchi_input_conditioner_if cond_if ();

   tamagotchi_input_conditioner #(
      .DEBOUNCE_CYCLES  (DB),
      .LONGPRESS_CYCLES (LP),
      .BTN_ACTIVE_LOW   (1'b1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .cond (cond_if)
   );

   // Event tallies used by the scenarios that only care about how many pulses occurred.
   always @(posedge clk) begin
      #1;
      if (cond_if.test_short)   n_short++;
      if (cond_if.test_long)    n_long++;
      if (cond_if.btn_press[4]) n_press4++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input btn_vec_t pressed, input logic tilt);
      cond_if.btn_raw  = ~pressed;
      cond_if.giro_raw = ~tilt;
   endtask

   task automatic press_test(input int hold_cycles, input int gap_cycles);
      applyStimulus(5'b10000, 1'b0);
      step(hold_cycles);
      applyStimulus(5'b00000, 1'b0);
      step(gap_cycles);
   endtask

   task automatic test_reset;
      logic [18:0] obs;
      rst = 1'b0;
      applyStimulus(5'b00000, 1'b0);
      step(2);
      obs = {cond_if.btn_level, cond_if.btn_press, cond_if.giro_level, cond_if.giro_edge,
             cond_if.test_long, cond_if.test_short, cond_if.test_mode, cond_if.pulse_test};
      total++;
      if (obs !== 19'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%h exp=0", obs);
      end
      rst = 1'b1;
      step(10);
      obs = {cond_if.btn_level, cond_if.btn_press, cond_if.giro_level, cond_if.giro_edge,
             cond_if.test_long, cond_if.test_short, cond_if.test_mode, cond_if.pulse_test};
      total++;
      if (obs !== 19'd0) begin
         bad++;
         $display("[TB] FAIL idle_outputs got=%h exp=0", obs);
      end
   endtask

   task automatic test_feed_press;
      applyStimulus(5'b00100, 1'b0);
      for (int i = 1; i <= 30; i++) begin
         step(1);
         total++;
         if (cond_if.btn_level[2] !== (i >= 6)) begin
            bad++;
            $display("[TB] FAIL feed_level cyc=%0d got=%b exp=%b", i, cond_if.btn_level[2], i >= 6);
         end
         total++;
         if (cond_if.btn_press !== ((i == 6) ? 5'b00100 : 5'b00000)) begin
            bad++;
            $display("[TB] FAIL feed_press cyc=%0d got=%b exp=%b", i, cond_if.btn_press,
                     (i == 6) ? 5'b00100 : 5'b00000);
         end
      end
      applyStimulus(5'b00000, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step(1);
         total++;
         if (cond_if.btn_level[2] !== (i < 6)) begin
            bad++;
            $display("[TB] FAIL feed_release_level cyc=%0d got=%b exp=%b", i, cond_if.btn_level[2], i < 6);
         end
         total++;
         if (cond_if.btn_press !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL feed_release_press cyc=%0d got=%b exp=00000", i, cond_if.btn_press);
         end
      end
   endtask

   task automatic test_bounce;
      for (int k = 0; k < 12; k++) begin
         if (k < 10) applyStimulus((k % 2 == 0) ? 5'b01000 : 5'b00000, 1'b0);
         else        applyStimulus(5'b00000, 1'b0);
         for (int j = 0; j < 2; j++) begin
            step(1);
            total++;
            if ({cond_if.btn_level[3], cond_if.btn_press[3]} !== 2'b00) begin
               bad++;
               $display("[TB] FAIL bounce_play cyc=%0d got=%b%b exp=00", 2 * k + j,
                        cond_if.btn_level[3], cond_if.btn_press[3]);
            end
         end
      end
   endtask

   task automatic test_long_press;
      int s0;
      int l0;
      applyStimulus(5'b10000, 1'b0);
      for (int i = 1; i <= 30; i++) begin
         step(1);
         total++;
         if (cond_if.test_long !== (i == 26)) begin
            bad++;
            $display("[TB] FAIL long_pulse cyc=%0d got=%b exp=%b", i, cond_if.test_long, i == 26);
         end
         total++;
         if (cond_if.test_mode !== (i >= 27)) begin
            bad++;
            $display("[TB] FAIL long_mode cyc=%0d got=%b exp=%b", i, cond_if.test_mode, i >= 27);
         end
         total++;
         if (cond_if.btn_press[4] !== (i == 6)) begin
            bad++;
            $display("[TB] FAIL long_press4 cyc=%0d got=%b exp=%b", i, cond_if.btn_press[4], i == 6);
         end
      end
      applyStimulus(5'b00000, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         step(1);
         total++;
         if (cond_if.test_short !== 1'b0) begin
            bad++;
            $display("[TB] FAIL long_release_short cyc=%0d got=%b exp=0", i, cond_if.test_short);
         end
      end
      // First short press checked cycle by cycle, the other two by tally.
      applyStimulus(5'b10000, 1'b0);
      step(8);
      applyStimulus(5'b00000, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step(1);
         total++;
         if (cond_if.test_short !== (i == 6)) begin
            bad++;
            $display("[TB] FAIL short_pulse cyc=%0d got=%b exp=%b", i, cond_if.test_short, i == 6);
         end
         total++;
         if (cond_if.pulse_test !== ((i >= 7) ? 4'd1 : 4'd0)) begin
            bad++;
            $display("[TB] FAIL short_count cyc=%0d got=%0d exp=%0d", i, cond_if.pulse_test, (i >= 7) ? 1 : 0);
         end
      end
      s0 = n_short;
      press_test(8, 10);
      press_test(8, 10);
      total++;
      if (n_short - s0 !== 2) begin
         bad++;
         $display("[TB] FAIL short_tally got=%0d exp=2", n_short - s0);
      end
      total++;
      if (cond_if.pulse_test !== 4'd3) begin
         bad++;
         $display("[TB] FAIL pulse_test_three got=%0d exp=3", cond_if.pulse_test);
      end
      s0 = n_short;
      l0 = n_long;
      press_test(30, 12);
      total++;
      if ({cond_if.test_mode, cond_if.pulse_test} !== 5'd0) begin
         bad++;
         $display("[TB] FAIL leave_mode got=%b/%0d exp=0/0", cond_if.test_mode, cond_if.pulse_test);
      end
      total++;
      if ((n_long - l0) !== 1 || (n_short - s0) !== 0) begin
         bad++;
         $display("[TB] FAIL leave_events got long=%0d short=%0d exp long=1 short=0", n_long - l0, n_short - s0);
      end
   endtask

   task automatic test_wrap_and_idle;
      int s0;
      int p0;
      press_test(30, 12);
      total++;
      if (cond_if.test_mode !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wrap_enter_mode got=%b exp=1", cond_if.test_mode);
      end
      s0 = n_short;
      p0 = n_press4;
      for (int k = 0; k < 17; k++) press_test(8, 10);
      total++;
      if (cond_if.pulse_test !== 4'd1) begin
         bad++;
         $display("[TB] FAIL wrap_count got=%0d exp=1", cond_if.pulse_test);
      end
      total++;
      if ((n_short - s0) !== 17 || (n_press4 - p0) !== 17) begin
         bad++;
         $display("[TB] FAIL wrap_tally got short=%0d press=%0d exp 17/17", n_short - s0, n_press4 - p0);
      end
      press_test(30, 12);
      s0 = n_short;
      press_test(8, 10);
      total++;
      if ((n_short - s0) !== 1) begin
         bad++;
         $display("[TB] FAIL idle_short got=%0d exp=1", n_short - s0);
      end
      total++;
      if ({cond_if.test_mode, cond_if.pulse_test} !== 5'd0) begin
         bad++;
         $display("[TB] FAIL idle_count got=%b/%0d exp=0/0", cond_if.test_mode, cond_if.pulse_test);
      end
   endtask

   task automatic test_simultaneous;
      applyStimulus(5'b01001, 1'b1);
      for (int i = 1; i <= 12; i++) begin
         step(1);
         total++;
         if (cond_if.btn_press !== ((i == 6) ? 5'b01001 : 5'b00000)) begin
            bad++;
            $display("[TB] FAIL simul_press cyc=%0d got=%b exp=%b", i, cond_if.btn_press,
                     (i == 6) ? 5'b01001 : 5'b00000);
         end
         total++;
         if ({cond_if.giro_level, cond_if.giro_edge} !== {i >= 6, i == 6}) begin
            bad++;
            $display("[TB] FAIL giro_rise cyc=%0d got=%b%b exp=%b%b", i, cond_if.giro_level,
                     cond_if.giro_edge, i >= 6, i == 6);
         end
      end
      applyStimulus(5'b01001, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step(1);
         total++;
         if ({cond_if.giro_level, cond_if.giro_edge, cond_if.btn_press} !== {i < 6, i == 6, 5'b00000}) begin
            bad++;
            $display("[TB] FAIL giro_fall cyc=%0d got=%b%b/%b exp=%b%b/00000", i, cond_if.giro_level,
                     cond_if.giro_edge, cond_if.btn_press, i < 6, i == 6);
         end
      end
      applyStimulus(5'b00000, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         step(1);
         total++;
         if ({cond_if.giro_edge, cond_if.btn_press, cond_if.btn_level} !==
             {i == 6, 5'b00000, (i < 6) ? 5'b01001 : 5'b00000}) begin
            bad++;
            $display("[TB] FAIL giro_again cyc=%0d got=%b/%b/%b", i, cond_if.giro_edge,
                     cond_if.btn_press, cond_if.btn_level);
         end
      end
      applyStimulus(5'b00000, 1'b0);
      step(10);
   endtask

   task automatic test_reset_mid;
      logic [18:0] obs;
      int          s0;
      press_test(30, 12);
      applyStimulus(5'b10000, 1'b0);
      step(10);
      rst = 1'b0;
      step(1);
      obs = {cond_if.btn_level, cond_if.btn_press, cond_if.giro_level, cond_if.giro_edge,
             cond_if.test_long, cond_if.test_short, cond_if.test_mode, cond_if.pulse_test};
      total++;
      if (obs !== 19'd0) begin
         bad++;
         $display("[TB] FAIL mid_reset_outputs got=%h exp=0", obs);
      end
      rst = 1'b1;
      s0 = n_short;
      for (int i = 1; i <= 30; i++) begin
         step(1);
         total++;
         if ({cond_if.btn_press[4], cond_if.test_long, cond_if.test_mode} !== {i == 6, i == 26, i >= 27}) begin
            bad++;
            $display("[TB] FAIL after_reset cyc=%0d got=%b%b%b exp=%b%b%b", i, cond_if.btn_press[4],
                     cond_if.test_long, cond_if.test_mode, i == 6, i == 26, i >= 27);
         end
      end
      applyStimulus(5'b00000, 1'b0);
      step(12);
      total++;
      if (cond_if.test_mode !== 1'b1 || (n_short - s0) !== 0) begin
         bad++;
         $display("[TB] FAIL reset_end_mode got=%b short=%0d exp=1 short=0", cond_if.test_mode, n_short - s0);
      end
   endtask

   initial begin
      test_reset();
      test_feed_press();
      test_bounce();
      test_long_press();
      test_wrap_and_idle();
      test_simultaneous();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
